uart_piso_tx: RTL and testbench

UART_PISO_TX -- requirements
Module: uart_piso_tx

---
 rtl/uart_piso_tx_if.sv | 29 ++
 rtl/uart_piso_tx.sv | 170 +++++++++++++++++
 tb/tb_uart_piso_tx.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_piso_tx_if.sv
// uart_piso_tx_if -- bus bundle between a byte source and the UART transmitter.
//   baud_tick   : one-clk pulse per bit period (source -> transmitter)
//   send        : request to hand data_in over this cycle
//   data_in     : payload word, DATA_W bits, sent LSB first
//   ready       : transmitter holding register is empty
//   data_tx     : serial line, idle high
//   active_flag : a frame is on the line
//   done_flag   : one-clk pulse at the end of each frame
interface uart_piso_tx_if #(
  parameter int DATA_W = 8
);
  logic              baud_tick;
  logic              send;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              data_tx;
  logic              active_flag;
  logic              done_flag;

  modport master (
    output baud_tick, send, data_in,
    input  ready, data_tx, active_flag, done_flag
  );

  modport slave (
    input  baud_tick, send, data_in,
    output ready, data_tx, active_flag, done_flag
  );
endinterface

// File: rtl/uart_piso_tx.sv
// uart_piso_tx -- parallel-in serial-out UART transmitter with a one-word
// holding register, optional parity and one or two stop bits.
// Ports:
//   clk   : single clock, all state changes on the rising edge
//   reset : synchronous, active-high; returns the line to idle high
//   bus   : uart_piso_tx_if.slave (baud_tick, send, data_in in;
//           ready, data_tx, active_flag, done_flag out)
// Frame: start(0), DATA_W data bits LSB first, parity (if enabled),
// STOP_BITS stop bits (1). Every bit boundary falls on a baud_tick cycle.
module uart_piso_tx #(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic         clk,
  input  logic         reset,
  uart_piso_tx_if.slave bus
);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_piso_tx: DATA_W must be in 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_piso_tx: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_piso_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [3:0] LAST_DATA  = 4'(DATA_W - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
  localparam bit         HAS_PARITY = (PARITY_MODE != 0);
  localparam bit         ODD_PARITY = (PARITY_MODE == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_n;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic              hold_full, hold_full_n;
  logic              tx, tx_n;
  logic              active, active_n;
  logic              done, done_n;
  logic [DATA_W-1:0] hold_data, hold_data_n;
  logic              hold_par, hold_par_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              par, par_n;
  logic              accept;
  logic              load;

  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
    return (^d) ^ ODD_PARITY;
  endfunction

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    hold_full_n = hold_full;
    tx_n        = tx;
    active_n    = active;
    done_n      = 1'b0;
    hold_data_n = hold_data;
    hold_par_n  = hold_par;
    shift_n     = shift;
    par_n       = par;
    load        = 1'b0;
    // accept needs an empty holding register and load needs a full one,
    // so the two can never happen in the same cycle.
    accept      = bus.send && !hold_full;

    if (bus.baud_tick) begin
      case (state)
        IDLE: begin
          if (hold_full) begin
            load     = 1'b1;
            tx_n     = 1'b0;
            active_n = 1'b1;
            state_n  = START;
          end
        end
        START: begin
          tx_n      = shift[0];
          shift_n   = shift >> 1;
          bit_cnt_n = 4'd0;
          state_n   = DATA;
        end
        DATA: begin
          // bit_cnt indexes the data bit currently on the line
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_n = 4'd0;
            if (HAS_PARITY) begin
              tx_n    = par;
              state_n = PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = STOP;
            end
          end else begin
            tx_n      = shift[0];
            shift_n   = shift >> 1;
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
        PARITY: begin
          tx_n      = 1'b1;
          bit_cnt_n = 4'd0;
          state_n   = STOP;
        end
        STOP: begin
          if (bit_cnt == LAST_STOP) begin
            done_n    = 1'b1;
            bit_cnt_n = 4'd0;
            if (hold_full) begin
              // back-to-back: next start bit follows the stop bit directly
              load    = 1'b1;
              tx_n    = 1'b0;
              state_n = START;
            end else begin
              tx_n     = 1'b1;
              active_n = 1'b0;
              state_n  = IDLE;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (load) begin
      shift_n     = hold_data;
      par_n       = hold_par;
      hold_full_n = 1'b0;
    end
    if (accept) begin
      hold_data_n = bus.data_in;
      hold_par_n  = calc_parity(bus.data_in);
      hold_full_n = 1'b1;
    end
  end

  // Register stage: control state is reset, payload registers are not.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      hold_full <= hold_full_n;
      tx        <= tx_n;
      active    <= active_n;
      done      <= done_n;
    end
    hold_data <= hold_data_n;
    hold_par  <= hold_par_n;
    shift     <= shift_n;
    par       <= par_n;
  end

  assign bus.ready       = !hold_full;
  assign bus.data_tx     = tx;
  assign bus.active_flag = active;
  assign bus.done_flag   = done;

endmodule

// File: tb/tb_uart_piso_tx.sv
// tb_uart_piso_tx -- directed bench for uart_piso_tx.
// Three instances: A (8 bits, even parity, 1 stop), B (8 bits, odd parity,
// 2 stops), C (5 bits, no parity, 1 stop). baud_tick pulses every 4 clks.
module tb_uart_piso_tx;

  logic clk = 1'b0;
  logic reset;
  logic baud_tick;
  int   div;
  bit   edge_tick;

  always #5 clk = ~clk;

  logic       send_v [3];
  logic [8:0] din_v  [3];
  logic [2:0] tx, act, dn, rdy;

  uart_piso_tx_if #(.DATA_W(8)) if_a ();
  uart_piso_tx_if #(.DATA_W(8)) if_b ();
  uart_piso_tx_if #(.DATA_W(5)) if_c ();

  uart_piso_tx #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  uart_piso_tx #(.DATA_W(8), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));
  uart_piso_tx #(.DATA_W(5), .PARITY_MODE(0), .STOP_BITS(1)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c.slave));

  assign if_a.baud_tick = baud_tick;
  assign if_b.baud_tick = baud_tick;
  assign if_c.baud_tick = baud_tick;
  assign if_a.send      = send_v[0];
  assign if_b.send      = send_v[1];
  assign if_c.send      = send_v[2];
  assign if_a.data_in   = din_v[0][7:0];
  assign if_b.data_in   = din_v[1][7:0];
  assign if_c.data_in   = din_v[2][4:0];

  assign tx[0]  = if_a.data_tx;     assign tx[1]  = if_b.data_tx;     assign tx[2]  = if_c.data_tx;
  assign act[0] = if_a.active_flag; assign act[1] = if_b.active_flag; assign act[2] = if_c.active_flag;
  assign dn[0]  = if_a.done_flag;   assign dn[1]  = if_b.done_flag;   assign dn[2]  = if_c.done_flag;
  assign rdy[0] = if_a.ready;       assign rdy[1] = if_b.ready;       assign rdy[2] = if_c.ready;

  int tests;
  int fails;

  // results of the most recent watch() run
  logic bits [32];
  int   nbits;
  int   done_cnt;
  int   hold_viol;
  bit   timeout;
  bit   ready_low_at_2nd;

  // Advance one clk; inputs change 1 time unit after the edge.
  task automatic step();
    edge_tick = baud_tick;
    @(posedge clk);
    #1;
    div       = (div == 3) ? 0 : div + 1;
    baud_tick = (div == 3);
  endtask

  task automatic send_word(input int sel, input logic [8:0] w);
    send_v[sel] = 1'b1;
    din_v[sel]  = w;
    step();
    send_v[sel] = 1'b0;
  endtask

  // Records data_tx after every tick edge while active_flag is high, counts
  // done pulses and any line change off a tick. Stops when active_flag drops,
  // after max_bits recorded bits (if nonzero), or when the budget runs out.
  // With inj set, offers 0xAA once ready returns mid-frame, then 0x12 the
  // following cycle (which must be ignored).
  task automatic watch(input int sel, input int max_bits, input int budget, input bit inj);
    bit   started;
    int   stage;
    logic prev;
    nbits = 0; done_cnt = 0; hold_viol = 0; timeout = 1'b1;
    ready_low_at_2nd = 1'b0; started = 1'b0; stage = 0;
    prev = tx[sel];
    for (int c = 0; c < budget; c++) begin
      step();
      if (edge_tick) begin
        if (act[sel]) begin
          if (nbits < 32) bits[nbits] = tx[sel];
          nbits++;
        end
      end else if (tx[sel] !== prev) begin
        hold_viol++;
      end
      prev = tx[sel];
      if (dn[sel]) done_cnt++;
      if (act[sel]) started = 1'b1;
      if (inj) begin
        if (stage == 0 && nbits == 4 && rdy[sel]) begin
          send_v[sel] = 1'b1; din_v[sel] = 9'h0AA; stage = 1;
        end else if (stage == 1) begin
          ready_low_at_2nd = (rdy[sel] == 1'b0);
          send_v[sel] = 1'b1; din_v[sel] = 9'h012; stage = 2;
        end else if (stage == 2) begin
          send_v[sel] = 1'b0; stage = 3;
        end
      end
      if (max_bits > 0 && nbits >= max_bits) begin timeout = 1'b0; break; end
      if (started && !act[sel]) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin send_v[i] = 1'b1; din_v[i] = 9'h0FF; end
    for (int c = 0; c < 6; c++) step();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rdy[i] !== 1'b1) begin
        fails++; $display("FAIL reset_prio_ready[%0d]: got %b expected 1", i, rdy[i]);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) send_v[i] = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (tx[i] !== 1'b1) begin fails++; $display("FAIL reset_tx[%0d]: got %b expected 1", i, tx[i]); end
      tests++;
      if (act[i] !== 1'b0) begin fails++; $display("FAIL reset_active[%0d]: got %b expected 0", i, act[i]); end
      tests++;
      if (dn[i] !== 1'b0) begin fails++; $display("FAIL reset_done[%0d]: got %b expected 0", i, dn[i]); end
      tests++;
      if (rdy[i] !== 1'b1) begin fails++; $display("FAIL reset_ready[%0d]: got %b expected 1", i, rdy[i]); end
    end
  endtask

  task automatic test_even_parity();
    logic [10:0] exp_bits;
    exp_bits = 11'b10010000010;  // bit i = line value after tick i
    send_word(0, 9'h041);
    tests++;
    if (rdy[0] !== 1'b0) begin fails++; $display("FAIL even_ready_after_send: got %b expected 0", rdy[0]); end
    watch(0, 0, 200, 1'b0);
    tests++;
    if (timeout) begin fails++; $display("FAIL even_timeout: got 1 expected 0"); end
    tests++;
    if (nbits != 11) begin fails++; $display("FAIL even_active_ticks: got %0d expected 11", nbits); end
    for (int i = 0; i < 11; i++) begin
      tests++;
      if (bits[i] !== exp_bits[i]) begin
        fails++; $display("FAIL even_bit[%0d]: got %b expected %b", i, bits[i], exp_bits[i]);
      end
    end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL even_done_count: got %0d expected 1", done_cnt); end
    tests++;
    if (hold_viol != 0) begin fails++; $display("FAIL even_hold_between_ticks: got %0d expected 0", hold_viol); end
    tests++;
    if (tx[0] !== 1'b1 || rdy[0] !== 1'b1) begin
      fails++; $display("FAIL even_idle_after: got tx=%b ready=%b expected 1 1", tx[0], rdy[0]);
    end
  endtask

  task automatic test_odd_two_stop();
    logic [11:0] exp_bits;
    exp_bits = 12'b111010000010;
    // send lands on a baud_tick cycle with the transmitter idle and empty
    for (int c = 0; c < 8 && baud_tick !== 1'b1; c++) step();
    send_word(1, 9'h041);
    tests++;
    if (act[1] !== 1'b0 || rdy[1] !== 1'b0) begin
      fails++; $display("FAIL same_tick_send: got active=%b ready=%b expected 0 0", act[1], rdy[1]);
    end
    watch(1, 0, 200, 1'b0);
    tests++;
    if (timeout) begin fails++; $display("FAIL odd_timeout: got 1 expected 0"); end
    tests++;
    if (nbits != 12) begin fails++; $display("FAIL odd_frame_ticks: got %0d expected 12", nbits); end
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (bits[i] !== exp_bits[i]) begin
        fails++; $display("FAIL odd_bit[%0d]: got %b expected %b", i, bits[i], exp_bits[i]);
      end
    end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL odd_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp_bits;
    int          act_cnt;
    exp_bits = 22'b10101010100_10010101010;  // 0x55 frame then 0xAA frame
    send_word(0, 9'h055);
    watch(0, 0, 400, 1'b1);
    tests++;
    if (timeout) begin fails++; $display("FAIL b2b_timeout: got 1 expected 0"); end
    tests++;
    if (!ready_low_at_2nd) begin fails++; $display("FAIL b2b_ready_when_full: got 1 expected 0"); end
    tests++;
    if (nbits != 22) begin fails++; $display("FAIL b2b_active_ticks: got %0d expected 22", nbits); end
    for (int i = 0; i < 22; i++) begin
      tests++;
      if (bits[i] !== exp_bits[i]) begin
        fails++; $display("FAIL b2b_bit[%0d]: got %b expected %b", i, bits[i], exp_bits[i]);
      end
    end
    tests++;
    if (done_cnt != 2) begin fails++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); end
    tests++;
    if (hold_viol != 0) begin fails++; $display("FAIL b2b_hold_between_ticks: got %0d expected 0", hold_viol); end
    // the 0x12 offered while full must never reach the line
    act_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (act[0] || tx[0] !== 1'b1) act_cnt++;
    end
    tests++;
    if (act_cnt != 0) begin fails++; $display("FAIL ignored_send_sent: got %0d busy cycles expected 0", act_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    send_word(0, 9'h041);
    watch(0, 5, 200, 1'b0);  // start + 4 data bits: 4th data bit on the line
    tests++;
    if (timeout) begin fails++; $display("FAIL midreset_timeout: got 1 expected 0"); end
    send_word(0, 9'h012);    // fill the holding register, must be discarded
    step();
    tests++;
    if (rdy[0] !== 1'b0) begin fails++; $display("FAIL midreset_held: got ready=%b expected 0", rdy[0]); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (tx[0] !== 1'b1 || act[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      fails++;
      $display("FAIL midreset_outputs: got tx=%b active=%b ready=%b expected 1 0 1", tx[0], act[0], rdy[0]);
    end
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (dn[0] || act[0] || tx[0] !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL midreset_quiet: got %0d busy cycles expected 0", bad); end
  endtask

  task automatic test_narrow_no_parity();
    logic [6:0] exp_bits;
    exp_bits = 7'b1111110;
    send_word(2, 9'h01F);
    watch(2, 0, 200, 1'b0);
    tests++;
    if (timeout) begin fails++; $display("FAIL narrow_timeout: got 1 expected 0"); end
    tests++;
    if (nbits != 7) begin fails++; $display("FAIL narrow_frame_ticks: got %0d expected 7", nbits); end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (bits[i] !== exp_bits[i]) begin
        fails++; $display("FAIL narrow_bit[%0d]: got %b expected %b", i, bits[i], exp_bits[i]);
      end
    end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL narrow_done_count: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    div = 0;
    baud_tick = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin send_v[i] = 1'b0; din_v[i] = 9'h000; end
    test_reset();
    test_even_parity();
    test_odd_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    test_narrow_no_parity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
